tia_frame_capture: RTL and testbench
====================================

// Module: tia_frame_capture
// PURPOSE
//  Receiving end of the TIA video output. Samples l/c/syn/blk_bar once per color clock and
//  detects vertical and horizontal sync. Emits each visible pixel with its (x,y) position
//  through a small valid/ready FIFO, so frame dumps and scoring logic can consume frames
//  in hardware. Color packing matches the frame dump format: {c[3:0], l[2:0], 1'b0}.
// PARAMETERS
//  VSYNC_MIN   32  consecutive syn-high color clocks that classify a sync pulse as vertical
//  FIFO_DEPTH  4   pixel FIFO entries; power of two, >= 2
// PORTS
//  clock        in   1  color clock (osc domain); all logic on posedge
//  reset_bar    in   1  synchronous, active-low reset
//  l            in   3  TIA luminance
//  c            in   4  TIA chroma
//  syn          in   1  TIA composite sync, high = in sync
//  blk_bar      in   1  TIA blank, low = blanked
//  pixel_ready  in   1  consumer accepts the head pixel this cycle
//  pixel_valid  out  1  FIFO head is valid
//  pixel_x      out  8  visible-pixel index within line
//  pixel_y      out  9  visible-line index within frame
//  pixel_color  out  8  {c,l,1'b0}
//  frame_done   out  1  one-cycle pulse when a frame containing >=1 pixel ends
//  overflow     out  1  sticky; set when a pixel was dropped because the FIFO was full
//  in_frame     out  1  high while the state is ACTIVE
// BEHAVIOUR
//  - Reset (reset_bar=0 at posedge): FIFO empty, state SEEK, all counters 0.
//    All outputs 0. Applies mid-line or mid-frame; in-flight pixels are discarded.
//  - Input stage: l, c, syn and blk_bar are registered once. Register stage is "s*".
//  - sync_run: counts consecutive s_syn=1 cycles, saturating at VSYNC_MIN. Cleared when s_syn=0.
//  - States:
//    SEEK -> VSYNC when sync_run reaches VSYNC_MIN. No pixels are captured in SEEK.
//    VSYNC -> ACTIVE on first s_syn=0. Then x=0, y=0, line_has_pix=0, frame_has_pix=0.
//    ACTIVE -> VSYNC when sync_run reaches VSYNC_MIN.
//      On the same cycle, frame_done=1 for one cycle if frame_has_pix=1.
//  - Hsync in ACTIVE (s_syn rising edge): x<=0.
//      If line_has_pix=1: y<=y+1, saturating at 511. Then line_has_pix<=0.
//      A fully blanked line therefore does not advance y.
//      A syn pulse shorter than VSYNC_MIN is always hsync only.
//  - Capture in ACTIVE when s_blk_bar=1 and s_syn=0:
//      Push {x, y, color}. Then x<=x+1, line_has_pix<=1, frame_has_pix<=1.
//      At x=255, x saturates and further pixels on that line are dropped.
//      This drop does not set overflow.
//  - Latency: a pixel sampled at edge N is pushed at N+1 and visible on pixel_valid after N+1.
//      With an empty FIFO and ready=1, there are 2 cycles from input pin to pixel_valid.
//  - FIFO: show-ahead. pixel_x/y/color reflect the head whenever pixel_valid=1.
//      They hold the last head when empty. Pop occurs when pixel_valid & pixel_ready.
//      Push and pop on the same cycle when full: both succeed, count unchanged.
//      Push when full without a pop: pixel dropped, overflow<=1 (sticky until reset).
//      Order is strictly preserved.
//  - Transition to VSYNC does not flush the FIFO; queued pixels drain normally.
//  - Widths: x 8b, y 9b, sync_run ceil(log2(VSYNC_MIN+1))b. All counters saturate; none wrap.
// TESTING
//  T1 reset, then 300 clocks blk_bar=1 with no vsync -> pixel_valid stays 0; in_frame=0.
//  T2 syn high 40 clocks, low; line = 16 syn + 68 blank + 160 visible (l=7,c=1), ready=1
//     -> 160 pixels, x=0..159, y=0, color=8'h1E; first valid 2 clocks after first visible.
//  T3 three lines: visible, fully blanked, visible -> y=0, then y=1; no y=2.
//  T4 ready=0 for 10 visible clocks, FIFO_DEPTH=4 -> 4 pixels queued x=0..3, overflow=1.
//     Release ready -> x=0..3 then x=10; overflow stays 1 until reset.
//  T5 syn high 31 clocks mid-frame -> treated as hsync, no frame_done.
//     Syn high 32 clocks -> frame_done one cycle, VSYNC_MIN+1 clocks after syn rises.
//  T6 reset_bar low for 1 clock mid-line with 3 pixels queued -> pixel_valid=0 next cycle.
//     State returns to SEEK; no pixels until the next vsync.

Source files
------------

// File: rtl/tia_frame_capture.sv
// TIA video receiver: registers the raw TIA outputs, finds vertical and horizontal sync,
// and streams every visible pixel with its (x,y) position through a show-ahead FIFO.
module tia_frame_capture #(
  parameter int unsigned VSYNC_MIN  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_bar,
  input  logic [2:0] l,
  input  logic [3:0] c,
  input  logic       syn,
  input  logic       blk_bar,
  input  logic       pixel_ready,
  output logic       pixel_valid,
  output logic [7:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic [7:0] pixel_color,
  output logic       frame_done,
  output logic       overflow,
  output logic       in_frame
);

  localparam int unsigned SyncW  = $clog2(VSYNC_MIN + 1);
  localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW   = AddrW + 1;
  localparam int unsigned EntryW = 25;  // {x[7:0], y[8:0], color[7:0]}

  typedef enum logic [1:0] {StSeek, StVsync, StActive} state_e;

  // Input sample stage
  logic [2:0] s_l_q;
  logic [3:0] s_c_q;
  logic       s_syn_q;
  logic       s_blk_q;

  // Line/frame tracking
  state_e           state_q, state_d;
  logic [SyncW-1:0] sync_run_q, sync_run_d;
  logic [7:0]       x_q, x_d;
  logic [8:0]       y_q, y_d;
  logic             line_has_q, line_has_d;
  logic             frame_has_q, frame_has_d;
  logic             line_full_q, line_full_d;
  logic             frame_done_q, frame_done_d;
  logic             push;
  logic             vsync_hit;
  logic             hsync_edge;

  // FIFO
  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]   count;
  logic [AddrW-1:0]  head_idx;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push_ok;
  logic              overflow_q, overflow_d;
  logic [EntryW-1:0] push_data;

  // Register the TIA pins once per color clock
  always_ff @(posedge clock) begin
    if (!reset_bar) begin
      s_l_q   <= '0;
      s_c_q   <= '0;
      s_syn_q <= 1'b0;
      s_blk_q <= 1'b0;
    end else begin
      s_l_q   <= l;
      s_c_q   <= c;
      s_syn_q <= syn;
      s_blk_q <= blk_bar;
    end
  end

  // Saturating run length of sampled sync; a zero run length means the previous sample was low
  always_comb begin
    sync_run_d = '0;
    if (s_syn_q) begin
      sync_run_d = (sync_run_q == SyncW'(VSYNC_MIN)) ? sync_run_q : sync_run_q + SyncW'(1);
    end
    vsync_hit  = (sync_run_d == SyncW'(VSYNC_MIN));
    hsync_edge = s_syn_q && (sync_run_q == '0);
  end

  // Frame FSM next state, position counters and capture decision
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    line_has_d   = line_has_q;
    frame_has_d  = frame_has_q;
    line_full_d  = line_full_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    unique case (state_q)
      StSeek: begin
        if (vsync_hit) state_d = StVsync;
      end
      StVsync: begin
        if (!s_syn_q) begin
          state_d     = StActive;
          x_d         = '0;
          y_d         = '0;
          line_has_d  = 1'b0;
          frame_has_d = 1'b0;
          line_full_d = 1'b0;
        end
      end
      StActive: begin
        if (vsync_hit) begin
          state_d      = StVsync;
          frame_done_d = frame_has_q;
        end else if (hsync_edge) begin
          x_d         = '0;
          line_full_d = 1'b0;
          // Fully blanked lines do not consume a line number
          if (line_has_q && (y_q != 9'd511)) y_d = y_q + 9'd1;
          line_has_d = 1'b0;
        end else if (s_blk_q && !s_syn_q && !line_full_q) begin
          push        = 1'b1;
          line_has_d  = 1'b1;
          frame_has_d = 1'b1;
          if (x_q == 8'd255) line_full_d = 1'b1;
          else               x_d         = x_q + 8'd1;
        end
      end
      default: state_d = StSeek;
    endcase
  end

  // Frame FSM and counter registers
  always_ff @(posedge clock) begin
    if (!reset_bar) begin
      state_q      <= StSeek;
      sync_run_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      line_has_q   <= 1'b0;
      frame_has_q  <= 1'b0;
      line_full_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_run_q   <= sync_run_d;
      x_q          <= x_d;
      y_q          <= y_d;
      line_has_q   <= line_has_d;
      frame_has_q  <= frame_has_d;
      line_full_q  <= line_full_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO status, push/pop qualification and head selection
  always_comb begin
    count      = wr_ptr_q - rd_ptr_q;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (count == PtrW'(FIFO_DEPTH));
    pop        = !fifo_empty && pixel_ready;
    push_ok    = push && (!fifo_full || pop);
    overflow_d = overflow_q | (push && fifo_full && !pop);
    push_data  = {x_q, y_q, s_c_q, s_l_q, 1'b0};
    // When empty the slot behind the read pointer still holds the last head shown
    head_idx   = fifo_empty ? rd_ptr_q[AddrW-1:0] - AddrW'(1) : rd_ptr_q[AddrW-1:0];
  end

  // FIFO storage and pointers
  always_ff @(posedge clock) begin
    if (!reset_bar) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      overflow_q <= overflow_d;
      if (push_ok) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
        wr_ptr_q                   <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  assign pixel_valid = !fifo_empty;
  assign pixel_x     = mem_q[head_idx][24:17];
  assign pixel_y     = mem_q[head_idx][16:8];
  assign pixel_color = mem_q[head_idx][7:0];
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign in_frame    = (state_q == StActive);

endmodule

// File: tb/tb_tia_frame_capture.sv
// Bench for tia_frame_capture: line-level pixel model feeding an expected-pixel queue.
module tb_tia_frame_capture;

  localparam int unsigned VMIN = 32;

  logic       clock = 1'b0;
  logic       reset_bar;
  logic [2:0] l;
  logic [3:0] c;
  logic       syn;
  logic       blk_bar;
  logic       pixel_ready;
  logic       pixel_valid;
  logic [7:0] pixel_x;
  logic [8:0] pixel_y;
  logic [7:0] pixel_color;
  logic       frame_done;
  logic       overflow;
  logic       in_frame;

  tia_frame_capture #(
    .VSYNC_MIN (VMIN),
    .FIFO_DEPTH(4)
  ) dut (
    .clock      (clock),
    .reset_bar  (reset_bar),
    .l          (l),
    .c          (c),
    .syn        (syn),
    .blk_bar    (blk_bar),
    .pixel_ready(pixel_ready),
    .pixel_valid(pixel_valid),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_color(pixel_color),
    .frame_done (frame_done),
    .overflow   (overflow),
    .in_frame   (in_frame)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [24:0] exp_q[$];
  int step_n           = 0;
  int first_valid_step = -1;
  bit saw_valid        = 1'b0;
  int fd_count         = 0;
  int fd_expect        = 0;
  int fd_step          = -1;
  int pix_seen         = 0;
  logic [8:0] last_y   = '0;

  // Line-level model of the frame: which visible samples become pixels, and where
  bit m_active    = 1'b0;
  int m_x         = 0;
  int m_y         = 0;
  bit m_line_has  = 1'b0;
  bit m_frame_has = 1'b0;

  // One color clock: apply inputs, observe outputs at negedge (popping checked pixels)
  task automatic step(input logic s, input logic b, input logic [2:0] ll, input logic [3:0] cc);
    logic [24:0] got;
    logic [24:0] e;
    syn = s; blk_bar = b; l = ll; c = cc;
    @(negedge clock);
    if (pixel_valid) begin
      if (!saw_valid) first_valid_step = step_n;
      saw_valid = 1'b1;
    end
    if (frame_done) begin
      fd_count++;
      fd_step = step_n;
    end
    if (reset_bar && pixel_valid && pixel_ready) begin
      got = {pixel_x, pixel_y, pixel_color};
      pix_seen++;
      last_y = pixel_y;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pixel_extra: got x=%0d y=%0d color=%h, expected no pixel",
                 pixel_x, pixel_y, pixel_color);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          miscompares++;
          $display("FAIL pixel: got x=%0d y=%0d color=%h, expected x=%0d y=%0d color=%h",
                   got[24:17], got[16:8], got[7:0], e[24:17], e[16:8], e[7:0]);
        end
      end
    end
    @(posedge clock);
    #1;
    step_n++;
  endtask

  task automatic apply_reset();
    reset_bar   = 1'b0;
    pixel_ready = 1'b1;
    step(1'b0, 1'b0, 3'd0, 4'd0);
    step(1'b0, 1'b0, 3'd0, 4'd0);
    reset_bar = 1'b1;
    exp_q.delete();
    m_active = 1'b0; m_x = 0; m_y = 0; m_line_has = 1'b0; m_frame_has = 1'b0;
  endtask

  // A syn-high pulse of n clocks: vsync when long enough, otherwise an hsync in a frame
  task automatic sync_pulse(input int n);
    if (m_active) begin
      m_x = 0;
      if (m_line_has && m_y < 511) m_y++;
      m_line_has = 1'b0;
    end
    for (int i = 0; i < n; i++) step(1'b1, 1'($urandom), 3'($urandom), 4'($urandom));
    if (n >= VMIN) begin
      if (m_active && m_frame_has) fd_expect++;
      m_active = 1'b1; m_x = 0; m_y = 0; m_line_has = 1'b0; m_frame_has = 1'b0;
    end
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'($urandom), 4'($urandom));
  endtask

  // n visible-window clocks, each unblanked with probability pct%
  task automatic visible(input int n, input int pct, input bit rand_col);
    logic       b;
    logic [2:0] ll;
    logic [3:0] cc;
    for (int i = 0; i < n; i++) begin
      b  = ($urandom_range(99) < pct);
      ll = rand_col ? 3'($urandom) : 3'd7;
      cc = rand_col ? 4'($urandom) : 4'd1;
      if (b && m_active) begin
        if (m_x < 256) exp_q.push_back({8'(m_x), 9'(m_y), cc, ll, 1'b0});
        m_x++;
        m_line_has  = 1'b1;
        m_frame_has = 1'b1;
      end
      step(1'b0, b, ll, cc);
    end
  endtask

  task automatic line(input int sync_n, input int blank_n, input int vis_n, input int pct);
    sync_pulse(sync_n);
    blank(blank_n);
    visible(vis_n, pct, 1'b1);
  endtask

  task automatic check_drained(input string name);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d pixels still expected, required 0", name, exp_q.size());
    end
    vectors++;
    if (fd_count !== fd_expect) begin
      miscompares++;
      $display("FAIL %s_frame_done_count: got %0d, expected %0d", name, fd_count, fd_expect);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({pixel_valid, frame_done, overflow, in_frame} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got valid/done/ovf/in_frame=%b, expected 0000",
               {pixel_valid, frame_done, overflow, in_frame});
    end
    vectors++;
    if ({pixel_x, pixel_y, pixel_color} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_head: got x=%0d y=%0d color=%h, expected 0 0 00",
               pixel_x, pixel_y, pixel_color);
    end
    saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 3'($urandom), 4'($urandom));
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL seek_no_pixels: pixel_valid seen=%0b, expected 0", saw_valid);
    end
    vectors++;
    if (in_frame !== 1'b0) begin
      miscompares++;
      $display("FAIL seek_in_frame: got %0b, expected 0", in_frame);
    end
  endtask

  task automatic test_single_line();
    int vis_start;
    int pix0;
    apply_reset();
    saw_valid = 1'b0;
    sync_pulse(40);
    blank(4);
    vectors++;
    if (in_frame !== 1'b1) begin
      miscompares++;
      $display("FAIL in_frame_after_vsync: got %0b, expected 1", in_frame);
    end
    sync_pulse(16);
    blank(68);
    pix0      = pix_seen;
    vis_start = step_n;
    visible(160, 100, 1'b0);
    blank(8);
    vectors++;
    if (first_valid_step - vis_start !== 2) begin
      miscompares++;
      $display("FAIL first_valid_latency: got %0d clocks, expected 2",
               first_valid_step - vis_start);
    end
    vectors++;
    if (pix_seen - pix0 !== 160) begin
      miscompares++;
      $display("FAIL line_pixel_count: got %0d, expected 160", pix_seen - pix0);
    end
    vectors++;
    if ({pixel_valid, pixel_x, pixel_color} !== {1'b0, 8'd159, 8'h1E}) begin
      miscompares++;
      $display("FAIL hold_last_head: got valid=%0b x=%0d color=%h, expected 0 159 1e",
               pixel_valid, pixel_x, pixel_color);
    end
    check_drained("single_line");
  endtask

  task automatic test_blank_line();
    apply_reset();
    sync_pulse(40);
    blank(4);
    line(16, 10, 20, 100);
    line(16, 10, 20, 0);
    line(16, 10, 20, 100);
    blank(8);
    vectors++;
    if (last_y !== 9'd1) begin
      miscompares++;
      $display("FAIL blank_line_y: last y got %0d, expected 1", last_y);
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL blank_line_overflow: got %0b, expected 0", overflow);
    end
    check_drained("blank_line");
  endtask

  task automatic test_overflow();
    logic [2:0] ll;
    logic [3:0] cc;
    apply_reset();
    sync_pulse(40);
    blank(4);
    sync_pulse(8);
    blank(4);
    for (int i = 0; i < 20; i++) begin
      pixel_ready = (i > 10);
      ll = 3'($urandom);
      cc = 4'($urandom);
      // Only the first four fit while stalled; the one arriving with the first pop also fits
      if (i < 4 || i >= 10) exp_q.push_back({8'(i), 9'd0, cc, ll, 1'b0});
      step(1'b0, 1'b1, ll, cc);
      if (i == 8) begin
        vectors++;
        if ({pixel_valid, pixel_x} !== {1'b1, 8'd0}) begin
          miscompares++;
          $display("FAIL stalled_head: got valid=%0b x=%0d, expected 1 0", pixel_valid, pixel_x);
        end
      end
    end
    m_x = 20; m_line_has = 1'b1; m_frame_has = 1'b1;
    pixel_ready = 1'b1;
    blank(8);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_set: got %0b, expected 1", overflow);
    end
    sync_pulse(40);
    blank(4);
    line(8, 4, 10, 100);
    blank(8);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: got %0b, expected 1", overflow);
    end
    check_drained("overflow");
    apply_reset();
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_reset: got %0b, expected 0", overflow);
    end
  endtask

  task automatic test_sync_len();
    int fd0;
    int st;
    apply_reset();
    sync_pulse(40);
    blank(4);
    line(16, 5, 10, 100);
    fd0 = fd_count;
    line(31, 5, 10, 100);
    blank(4);
    vectors++;
    if (fd_count !== fd0) begin
      miscompares++;
      $display("FAIL short_sync_no_done: frame_done pulses got %0d, expected 0", fd_count - fd0);
    end
    st = step_n;
    sync_pulse(32);
    blank(4);
    vectors++;
    if (fd_count - fd0 !== 1) begin
      miscompares++;
      $display("FAIL vsync_done_count: got %0d pulses, expected 1", fd_count - fd0);
    end
    vectors++;
    if (fd_step - st !== VMIN + 1) begin
      miscompares++;
      $display("FAIL vsync_done_timing: got %0d clocks after syn rise, expected %0d",
               fd_step - st, VMIN + 1);
    end
    line(16, 5, 10, 100);
    blank(8);
    check_drained("sync_len");
  endtask

  task automatic test_random_frames();
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      sync_pulse(VMIN + $urandom_range(16));
      blank(1 + $urandom_range(4));
      for (int n = 0; n < 6; n++) begin
        line(1 + $urandom_range(30), $urandom_range(20), $urandom_range(60),
             ($urandom_range(3) == 0) ? 0 : 40 + $urandom_range(60));
      end
      blank(8);
      check_drained("random_frame");
    end
    sync_pulse(VMIN);
    blank(6);
    check_drained("random_end");
  endtask

  task automatic test_reset_midline();
    apply_reset();
    sync_pulse(40);
    blank(4);
    sync_pulse(8);
    blank(4);
    pixel_ready = 1'b0;
    visible(3, 100, 1'b1);
    blank(2);
    vectors++;
    if ({pixel_valid, pixel_x} !== {1'b1, 8'd0}) begin
      miscompares++;
      $display("FAIL queued_before_reset: got valid=%0b x=%0d, expected 1 0",
               pixel_valid, pixel_x);
    end
    reset_bar = 1'b0;
    step(1'b0, 1'b1, 3'd5, 4'd5);
    reset_bar = 1'b1;
    exp_q.delete();
    m_active = 1'b0; m_x = 0; m_y = 0; m_line_has = 1'b0; m_frame_has = 1'b0;
    vectors++;
    if ({pixel_valid, in_frame, overflow} !== 3'b000) begin
      miscompares++;
      $display("FAIL midline_reset: got valid/in_frame/ovf=%b, expected 000",
               {pixel_valid, in_frame, overflow});
    end
    pixel_ready = 1'b1;
    saw_valid   = 1'b0;
    visible(50, 100, 1'b1);
    sync_pulse(8);
    visible(20, 100, 1'b1);
    vectors++;
    if (saw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_pixels_before_vsync: pixel_valid seen=%0b, expected 0", saw_valid);
    end
    sync_pulse(40);
    blank(4);
    line(8, 4, 10, 100);
    blank(8);
    vectors++;
    if (saw_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pixels_after_vsync: pixel_valid seen=%0b, expected 1", saw_valid);
    end
    check_drained("reset_midline");
  endtask

  initial begin
    reset_bar   = 1'b0;
    pixel_ready = 1'b1;
    syn         = 1'b0;
    blk_bar     = 1'b0;
    l           = '0;
    c           = '0;
    @(posedge clock);
    #1;
    test_reset();
    test_single_line();
    test_blank_line();
    test_overflow();
    test_sync_len();
    test_random_frames();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
